// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a private word-addressed SRAM.
// It handles one burst at a time, either a read or a write, and uses round-robin arbitration between AW and AR.
module axi_sram_slave #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_axi_awaddr,
   input  logic [7:0]  s_axi_awlen,
   input  logic [2:0]  s_axi_awsize,
   input  logic [1:0]  s_axi_awburst,
   input  logic        s_axi_awlock,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic [3:0]  s_axi_awqos,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic        s_axi_arlock,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic [3:0]  s_axi_arqos,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

   state_t            state, state_n;
   logic              pref_w;
   logic [31:0]       addr;
   logic [7:0]        len;
   logic [7:0]        beat_cnt;
   logic [2:0]        size;
   logic [1:0]        burst;
   logic [1:0]        resp_acc;
   logic [31:0]       mem [DEPTH];

   logic [IDX_W-1:0]  idx;
   logic [1:0]        beat_resp;
   logic [1:0]        w_resp;
   logic [1:0]        w_worst;
   logic              last_beat;
   logic [31:0]       addr_next;
   logic              aw_hs, ar_hs, w_hs, r_hs;

   logic unused_ok;
   assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, addr[1:0]};

   // The response encodings are ordered so that the numerically larger value is also the worse response.
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Per-beat decode of the current address together with the latched attributes.
   always_comb begin
      idx       = addr[ADDR_WIDTH-1:2];
      beat_resp = RESP_OKAY;
      if (addr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH])
         beat_resp = RESP_DECERR;
      else if (size != 3'b010 || burst[1])
         beat_resp = RESP_SLVERR;
      last_beat = (beat_cnt == len);
      addr_next = (burst == 2'b01) ? addr + 32'd4 : addr;
      w_resp    = resp_max(beat_resp, (s_axi_wlast != last_beat) ? RESP_SLVERR : RESP_OKAY);
      w_worst   = resp_max(resp_acc, w_resp);
      aw_hs     = s_axi_awvalid & s_axi_awready;
      ar_hs     = s_axi_arvalid & s_axi_arready;
      w_hs      = s_axi_wvalid & s_axi_wready;
      r_hs      = s_axi_rvalid & s_axi_rready;
   end

   // Next-state logic and the address-channel ready signals, which are only high in IDLE.
   always_comb begin
      state_n       = state;
      s_axi_awready = 1'b0;
      s_axi_arready = 1'b0;
      case (state)
         IDLE: begin
            s_axi_awready = s_axi_awvalid & (~s_axi_arvalid | pref_w);
            s_axi_arready = s_axi_arvalid & (~s_axi_awvalid | ~pref_w);
            if (s_axi_awready)
               state_n = WDATA;
            else if (s_axi_arready)
               state_n = RFETCH;
         end
         WDATA:   if (w_hs && last_beat) state_n = WRESP;
         WRESP:   if (s_axi_bready) state_n = IDLE;
         RFETCH:  state_n = RDATA;
         RDATA:   if (s_axi_rready) state_n = s_axi_rlast ? IDLE : RFETCH;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pref_w       <= 1'b1;
         addr         <= '0;
         len          <= '0;
         size         <= '0;
         burst        <= '0;
         beat_cnt     <= '0;
         resp_acc     <= RESP_OKAY;
         s_axi_wready <= 1'b0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
         s_axi_rlast  <= 1'b0;
      end else begin
         state        <= state_n;
         s_axi_wready <= (state_n == WDATA);
         s_axi_bvalid <= (state_n == WRESP);
         s_axi_rvalid <= (state_n == RDATA);
         if (aw_hs) begin
            addr     <= s_axi_awaddr;
            len      <= s_axi_awlen;
            size     <= s_axi_awsize;
            burst    <= s_axi_awburst;
            beat_cnt <= '0;
            resp_acc <= RESP_OKAY;
            pref_w   <= ~pref_w;
         end else if (ar_hs) begin
            addr     <= s_axi_araddr;
            len      <= s_axi_arlen;
            size     <= s_axi_arsize;
            burst    <= s_axi_arburst;
            beat_cnt <= '0;
            pref_w   <= ~pref_w;
         end
         if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            addr     <= addr_next;
            resp_acc <= w_worst;
            if (last_beat)
               s_axi_bresp <= w_worst;
         end
         if (state == RFETCH) begin
            s_axi_rdata <= (beat_resp == RESP_OKAY) ? mem[idx] : 32'd0;
            s_axi_rresp <= beat_resp;
            s_axi_rlast <= last_beat;
         end
         if (r_hs && !s_axi_rlast) begin
            addr     <= addr_next;
            beat_cnt <= beat_cnt + 8'd1;
         end
      end
   end

   // The RAM array is not reset. Beats that carry an error response never write it.
   always_ff @(posedge clk) begin
      if (w_hs && beat_resp == RESP_OKAY && !rst) begin
         for (int i = 0; i < 4; i++)
            if (s_axi_wstrb[i])
               mem[idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
   end

endmodule
